// File: rtl/mc_pkg.sv
// Shared types and constants for the motion-compensation residual block.
// The MC_SAT_EN build uses sat_limit() to clamp each lane to the signed pixel range.
package mc_pkg;

  localparam int MB_SIZE_DEF     = 4;
  localparam int PIXEL_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } mc_state_e;

  // Signed bound of a w-bit lane: upper (2^(w-1)-1) or lower (-2^(w-1)).
  function automatic int sat_limit(input int w, input bit lower);
    return lower ? -(2 ** (w - 1)) : (2 ** (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/mc_residual_lane.sv
// Single-lane residual: curr_px - ref_px, wrapping by default.
// With MC_SAT_EN defined the difference is clamped to the signed pixel range instead.
module mc_residual_lane
  import mc_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
) (
  input  logic [PIXEL_WIDTH-1:0] curr_px,
  input  logic [PIXEL_WIDTH-1:0] ref_px,
  output logic [PIXEL_WIDTH-1:0] res_px
);

`ifdef MC_SAT_EN
  localparam logic signed [PIXEL_WIDTH:0] SAT_HI = (PIXEL_WIDTH + 1)'(sat_limit(PIXEL_WIDTH, 1'b0));
  localparam logic signed [PIXEL_WIDTH:0] SAT_LO = (PIXEL_WIDTH + 1)'(sat_limit(PIXEL_WIDTH, 1'b1));

  logic signed [PIXEL_WIDTH:0] diff;

  always_comb begin
    diff = $signed({1'b0, curr_px}) - $signed({1'b0, ref_px});
    if (diff > SAT_HI) begin
      res_px = SAT_HI[PIXEL_WIDTH-1:0];
    end else if (diff < SAT_LO) begin
      res_px = SAT_LO[PIXEL_WIDTH-1:0];
    end else begin
      res_px = diff[PIXEL_WIDTH-1:0];
    end
  end
`else
  assign res_px = curr_px - ref_px;
`endif

endmodule

// File: rtl/motion_compensation.sv
// Per-pixel residual (current - reference) for one packed block, IDLE/CALC/OUT controller.
// Optional MC_SAT_EN macro selects saturating lanes instead of modulo wrap.
module motion_compensation
  import mc_pkg::*;
#(
  parameter int MB_SIZE     = MB_SIZE_DEF,
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PIXEL_WIDTH*MB_SIZE-1:0] ref_frame,
  input  logic [PIXEL_WIDTH*MB_SIZE-1:0] curr_mb,
  input  logic                           src_valid,
  output logic                           src_ready,
  output logic                           dst_valid,
  input  logic                           dst_ready,
  output logic [PIXEL_WIDTH*MB_SIZE-1:0] residual,
  output logic [1:0]                     state_dbg
);

  localparam int BW = PIXEL_WIDTH * MB_SIZE;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // src_ready is high only in IDLE (and low during reset); dst_valid is high only in OUT
  // and falls solely after an edge with dst_ready high. residual is stable while dst_valid.

  mc_state_e     state, state_next;
  logic [BW-1:0] ref_lat, curr_lat, res_next;

  assign state_dbg = state;

  for (genvar i = 0; i < MB_SIZE; i++) begin : g_lane
    mc_residual_lane #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_lane (
      .curr_px(curr_lat[i*PIXEL_WIDTH +: PIXEL_WIDTH]),
      .ref_px (ref_lat[i*PIXEL_WIDTH +: PIXEL_WIDTH]),
      .res_px (res_next[i*PIXEL_WIDTH +: PIXEL_WIDTH])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    src_ready  = 1'b0;
    dst_valid  = 1'b0;
    case (state)
      IDLE: begin
        src_ready = !reset;
        if (src_valid) state_next = CALC;
      end
      CALC: state_next = OUT;
      OUT: begin
        dst_valid = 1'b1;
        if (dst_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_lat  <= '0;
      curr_lat <= '0;
      residual <= '0;
    end else begin
      if (state == IDLE && src_valid) begin
        ref_lat  <= ref_frame;
        curr_lat <= curr_mb;
      end
      // residual is only rewritten in CALC, so it persists after the output handshake.
      if (state == CALC) residual <= res_next;
    end
  end

endmodule

// File: tb/tb_motion_compensation.sv
// Bench for motion_compensation: directed table, random vectors against a lane-arithmetic
// model, backpressure, reset mid-transaction and back-to-back spacing sequences.
module tb_motion_compensation;

  localparam int PW = 8;
  localparam int MB = 4;
  localparam int BW = PW * MB;
  localparam int N_DIR = 8;
  localparam int N_RND = 20;
  localparam int N_VEC = N_DIR + N_RND;

  typedef struct {
    logic [BW-1:0] refv;
    logic [BW-1:0] curr;
    logic [BW-1:0] exp;
  } vec_t;

  logic          clk;
  logic          reset;
  logic [BW-1:0] ref_frame, curr_mb, residual;
  logic          src_valid, src_ready, dst_valid, dst_ready;
  logic [1:0]    state_dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vec_t          tbl[N_VEC];
  logic [BW-1:0] exp_q[$];

  motion_compensation #(.MB_SIZE(MB), .PIXEL_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .ref_frame(ref_frame), .curr_mb(curr_mb),
    .src_valid(src_valid), .src_ready(src_ready), .dst_valid(dst_valid),
    .dst_ready(dst_ready), .residual(residual), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each lane is an independent integer difference.
  function automatic logic [BW-1:0] model(input logic [BW-1:0] c, input logic [BW-1:0] r);
    logic [BW-1:0] out;
    int d;
    out = '0;
    for (int i = 0; i < MB; i++) begin
      d = int'(c[i*PW +: PW]) - int'(r[i*PW +: PW]);
`ifdef MC_SAT_EN
      if (d > (2 ** (PW - 1)) - 1) d = (2 ** (PW - 1)) - 1;
      if (d < -(2 ** (PW - 1))) d = -(2 ** (PW - 1));
`endif
      out[i*PW +: PW] = d[PW-1:0];
    end
    return out;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: accept one block from IDLE, run it through CALC/OUT and check every step.
  task automatic run_txn(input logic [BW-1:0] r, input logic [BW-1:0] c, input string name);
    logic [BW-1:0] exp;
    exp_q.push_back(model(c, r));
    check({name, " src_ready idle"}, BW'(src_ready), BW'(1));
    ref_frame = r;
    curr_mb   = c;
    src_valid = 1'b1;
    dst_ready = 1'b0;
    tick();
    src_valid = 1'b0;
    ref_frame = BW'($urandom);
    curr_mb   = BW'($urandom);
    dst_ready = 1'($urandom_range(0, 1));
    check({name, " calc dst_valid"}, BW'(dst_valid), BW'(0));
    check({name, " calc src_ready"}, BW'(src_ready), BW'(0));
    tick();
    exp = exp_q.pop_front();
    check({name, " out dst_valid"}, BW'(dst_valid), BW'(1));
    check({name, " residual"}, residual, exp);
    dst_ready = 1'b1;
    tick();
    dst_ready = 1'b0;
    check({name, " done dst_valid"}, BW'(dst_valid), BW'(0));
    check({name, " residual kept"}, residual, exp);
  endtask

  initial begin
    logic [BW-1:0] held, res_a, res_b;
    logic [5:0]    dv_hist;

    // Directed vectors (lanes listed MSB first in the literals).
    tbl[0] = '{{8'd55, 8'd23, 8'd1, 8'd2}, {8'd60, 8'd30, 8'd5, 8'd10}, {8'd5, 8'd7, 8'd4, 8'd8}};
    tbl[1] = '{{8'd10, 8'd15, 8'd20, 8'd25}, {8'd15, 8'd20, 8'd25, 8'd30}, 32'h05050505};
    tbl[2] = '{{8'd30, 8'd35, 8'd40, 8'd45}, {8'd35, 8'd40, 8'd45, 8'd50}, 32'h05050505};
    tbl[3] = '{{8'd50, 8'd55, 8'd60, 8'd65}, {8'd55, 8'd60, 8'd65, 8'd70}, 32'h05050505};
    tbl[4] = '{{8'd10, 8'd10, 8'd10, 8'd10}, {8'd2, 8'd2, 8'd2, 8'd2}, 32'hF8F8F8F8};
    tbl[5] = '{{8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 32'h00000000};
`ifdef MC_SAT_EN
    tbl[6] = '{{8'd200, 8'd10, 8'd10, 8'd0}, {8'd0, 8'd2, 8'd200, 8'd0}, 32'h80F87F00};
    tbl[7] = '{{8'd0, 8'd255, 8'd128, 8'd127}, {8'd255, 8'd0, 8'd0, 8'd0}, 32'h7F808081};
`else
    tbl[6] = '{{8'd200, 8'd10, 8'd10, 8'd0}, {8'd0, 8'd2, 8'd200, 8'd0}, 32'h38F8BE00};
    tbl[7] = '{{8'd0, 8'd255, 8'd128, 8'd127}, {8'd255, 8'd0, 8'd0, 8'd0}, 32'hFF018081};
`endif
    for (int i = N_DIR; i < N_VEC; i++) begin
      tbl[i].refv = BW'($urandom);
      tbl[i].curr = BW'($urandom);
      tbl[i].exp  = model(tbl[i].curr, tbl[i].refv);
    end

    reset     = 1'b1;
    ref_frame = '0;
    curr_mb   = '0;
    src_valid = 1'b0;
    dst_ready = 1'b0;
    #1;
    check("reset src_ready", BW'(src_ready), BW'(0));
    check("reset dst_valid", BW'(dst_valid), BW'(0));
    check("reset residual", residual, '0);
    check("reset state", BW'(state_dbg), BW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // The table expectations must agree with the model before they are trusted.
    for (int i = 0; i < N_VEC; i++) begin
      check($sformatf("vec%0d model", i), model(tbl[i].curr, tbl[i].refv), tbl[i].exp);
      run_txn(tbl[i].refv, tbl[i].curr, $sformatf("vec%0d", i));
    end

    // Backpressure: inputs toggle and src_valid is high while OUT stalls.
    ref_frame = 32'h01020304;
    curr_mb   = 32'h11121314;
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    tick();
    held = residual;
    check("bp residual", held, 32'h10101010);
    for (int k = 0; k < 5; k++) begin
      ref_frame = BW'($urandom);
      curr_mb   = BW'($urandom);
      src_valid = 1'b1;
      tick();
      check($sformatf("bp%0d dst_valid", k), BW'(dst_valid), BW'(1));
      check($sformatf("bp%0d residual", k), residual, held);
      check($sformatf("bp%0d src_ready", k), BW'(src_ready), BW'(0));
    end
    src_valid = 1'b0;
    dst_ready = 1'b1;
    tick();
    dst_ready = 1'b0;
    check("bp release dst_valid", BW'(dst_valid), BW'(0));
    check("bp release src_ready", BW'(src_ready), BW'(1));
    check("bp release state", BW'(state_dbg), BW'(0));

    // Reset during CALC.
    ref_frame = 32'h00000000;
    curr_mb   = 32'h22222222;
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst calc dst_valid", BW'(dst_valid), BW'(0));
    check("rst calc residual", residual, '0);
    check("rst calc src_ready", BW'(src_ready), BW'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst calc idle", BW'(src_ready), BW'(1));
    run_txn(32'h01010101, 32'h09090909, "post rst calc");

    // Reset during OUT.
    ref_frame = 32'h00000000;
    curr_mb   = 32'h33333333;
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    tick();
    check("rst out pre dst_valid", BW'(dst_valid), BW'(1));
    reset = 1'b1;
    #1;
    check("rst out dst_valid", BW'(dst_valid), BW'(0));
    check("rst out residual", residual, '0);
    check("rst out src_ready", BW'(src_ready), BW'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst out idle", BW'(src_ready), BW'(1));
    run_txn(32'h0A0B0C0D, 32'h02030405, "post rst out");

    // src_valid held across two transactions with dst_ready high: results 3 cycles apart.
    ref_frame = 32'h10203040;
    curr_mb   = 32'h11223344;
    src_valid = 1'b1;
    dst_ready = 1'b1;
    tick();
    ref_frame = 32'h05050505;
    curr_mb   = 32'h01010101;
    res_a   = '0;
    res_b   = '0;
    dv_hist = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      dv_hist[k] = dst_valid;
      if (k == 0) res_a = residual;
      if (k == 3) res_b = residual;
      if (k == 4) src_valid = 1'b0;
    end
    dst_ready = 1'b0;
    check("b2b dst_valid pattern", BW'(dv_hist), BW'(6'b001001));
    check("b2b first residual", res_a, model(32'h11223344, 32'h10203040));
    check("b2b second residual", res_b, model(32'h01010101, 32'h05050505));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
